// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings for the memory port arbiter.
// Holds the FSM states, load/store size codes and master ids.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'b001,
    ARB_BUSY = 3'b010,
    ARB_RESP = 3'b100
  } arb_state_e;

  typedef enum logic [1:0] {
    LS_B = 2'b00,
    LS_H = 2'b01,
    LS_W = 2'b10
  } mem_type_bus_e;

  localparam logic MASTER_CORE = 1'b0;
  localparam logic MASTER_DBG  = 1'b1;

  localparam int TMO_W    = 8;
  localparam int STARVE_W = 4;

  // Debug master wins when the core is quiet or has starved it.
  function automatic logic arb_pick_dbg(
    input logic m0_req,
    input logic m1_req,
    input logic starved
  );
    return m1_req & (~m0_req | starved);
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt: loadable saturating up-counter.
// Clear beats load beats enable; tc flags cnt >= tc_val.
module arb_timeout_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Count register, sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt >= tc_val);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between core and debug.
// Core has priority; debug is forced after STARVE_MAX losses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [1:0]        m0_type,
  input  logic              m0_sign,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [1:0]        m1_type,
  input  logic              m1_sign,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_type,
  output logic              mem_sign,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       grant_q;
  logic       grant_d;

  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic is_idle;
  logic is_busy;
  logic is_resp;
  logic any_req;
  logic pick_m1;
  logic ack_ok;

  logic [TMO_W-1:0]    tmo_cnt;
  logic                tmo_tc;
  logic                tmo_clr;
  logic                tmo_en;
  logic [STARVE_W-1:0] starve_cnt;
  logic                starve_ge;
  logic                starve_clr;
  logic                starve_en;

  assign is_idle = (state_q == ARB_IDLE);
  assign is_busy = (state_q == ARB_BUSY);
  assign is_resp = (state_q == ARB_RESP);
  assign any_req = m0_req | m1_req;
  assign pick_m1 = arb_pick_dbg(m0_req, m1_req, starve_ge);
  assign ack_ok  = is_busy & mem_ack;

  // Timeout runs only while BUSY and restarts on any exit.
  assign tmo_clr = ~is_busy | ack_ok | tmo_tc;
  assign tmo_en  = is_busy;

  arb_timeout_cnt #(
    .W (TMO_W)
  ) u_tmo_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmo_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (tmo_en),
    .tc_val   (TMO_W'(TIMEOUT - 1)),
    .cnt      (tmo_cnt),
    .tc       (tmo_tc)
  );

  // Starvation counts core wins over a waiting debug request.
  assign starve_clr = is_idle & pick_m1;
  assign starve_en  = is_idle & m1_req & ~pick_m1;

  arb_timeout_cnt #(
    .W (STARVE_W)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (starve_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (starve_en),
    .tc_val   (STARVE_W'(STARVE_MAX)),
    .cnt      (starve_cnt),
    .tc       (starve_ge)
  );

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= MASTER_CORE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next-state and grant selection.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (1'b1)
      (state_q == ARB_IDLE): begin
        if (any_req) begin
          state_d = ARB_BUSY;
          grant_d = pick_m1 ? MASTER_DBG : MASTER_CORE;
        end
      end
      (state_q == ARB_BUSY): begin
        if (ack_ok || tmo_tc) begin
          state_d = ARB_RESP;
        end
      end
      (state_q == ARB_RESP): begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Command latch on grant; response capture on ack or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_type  <= 2'b00;
      mem_sign  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (is_idle && any_req) begin
        mem_we    <= pick_m1 ? m1_we    : m0_we;
        mem_addr  <= pick_m1 ? m1_addr  : m0_addr;
        mem_wdata <= pick_m1 ? m1_wdata : m0_wdata;
        mem_type  <= pick_m1 ? m1_type  : m0_type;
        mem_sign  <= pick_m1 ? m1_sign  : m0_sign;
      end
      if (ack_ok) begin
        rdata_q <= mem_we ? '0 : mem_rdata;
        err_q   <= 1'b0;
      end else if (is_busy && tmo_tc) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign mem_req = is_busy;

  assign m0_ack   = is_resp & (grant_q == MASTER_CORE);
  assign m1_ack   = is_resp & (grant_q == MASTER_DBG);
  assign m0_rdata = m0_ack ? rdata_q : '0;
  assign m1_rdata = m1_ack ? rdata_q : '0;
  assign m0_err   = m0_ack & err_q;
  assign m1_err   = m1_ack & err_q;
  assign m0_stall = m0_req & ~m0_ack;

endmodule
